// File: rtl/rename_reg_file_pkg.sv
// ============================================================================
// Module : rename_reg_file_pkg
// Brief  : Shared constants for the rename register file and its read ports.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rename_reg_file_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREG_DEF  = 32;
    localparam int ROB_W_DEF = 4;

    // Register 0 is hardwired zero; tag 0 means "no producer pending".
    localparam int REG_ZERO  = 0;
    localparam int TAG_NONE  = 0;

endpackage : rename_reg_file_pkg

`default_nettype wire

// File: rtl/rename_reg_file_read_port.sv
// ============================================================================
// Module : rrf_read_port
// Brief  : One combinational read port: x0 handling, same-cycle commit value
//          forwarding and busy/tag clear forwarding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rrf_read_port
    import rename_reg_file_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int RW     = 5,
    parameter int ROB_W  = ROB_W_DEF,
    parameter int NUM_CM = 2
) (
    input  logic [RW-1:0]           rs_i,
    input  logic [XLEN-1:0]         reg_val_i,
    input  logic                    reg_busy_i,
    input  logic [ROB_W-1:0]        reg_tag_i,
    input  logic [NUM_CM-1:0]       cm_en_i,
    input  logic [NUM_CM*RW-1:0]    cm_rd_i,
    input  logic [NUM_CM*ROB_W-1:0] cm_tag_i,
    input  logic [NUM_CM*XLEN-1:0]  cm_val_i,
    output logic [XLEN-1:0]         val_o,
    output logic                    busy_o,
    output logic [ROB_W-1:0]        tag_o
);

    logic w_clear;

    // Youngest matching commit supplies the value; a tag match on a busy entry clears it.
    always_comb begin
        val_o   = reg_val_i;
        busy_o  = reg_busy_i;
        tag_o   = reg_tag_i;
        w_clear = 1'b0;
        for (int j = 0; j < NUM_CM; j++) begin
            if (cm_en_i[j] && (cm_rd_i[j*RW +: RW] == rs_i)) begin
                val_o = cm_val_i[j*XLEN +: XLEN];
                if (reg_busy_i && (cm_tag_i[j*ROB_W +: ROB_W] == reg_tag_i)) begin
                    w_clear = 1'b1;
                end
            end
        end
        if (w_clear) begin
            busy_o = 1'b0;
            tag_o  = ROB_W'(TAG_NONE);
        end
        if (rs_i == RW'(REG_ZERO)) begin
            val_o  = '0;
            busy_o = 1'b0;
            tag_o  = ROB_W'(TAG_NONE);
        end
    end

endmodule : rrf_read_port

`default_nettype wire

// File: rtl/rename_reg_file.sv
// ============================================================================
// Module : rename_reg_file
// Brief  : Architectural register file with per-register rename table
//          (busy + ROB tag), NUM_RD read ports, one rename per cycle,
//          NUM_CM ordered commits per cycle and rollback.
// Config : RRF_COMMIT_CNT_EN adds the 32-bit committed-instruction counter
//          output cm_cnt_out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rename_reg_file
    import rename_reg_file_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int ROB_W  = ROB_W_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_CM = 2,
    parameter int RW     = $clog2(NREG)
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    rdy_in,
    input  logic [NUM_RD*RW-1:0]    rs_in,
    output logic [NUM_RD*XLEN-1:0]  val_out,
    output logic [NUM_RD-1:0]       busy_out,
    output logic [NUM_RD*ROB_W-1:0] tag_out,
    input  logic                    ren_en_in,
    input  logic [RW-1:0]           ren_rd_in,
    input  logic [ROB_W-1:0]        ren_tag_in,
    input  logic [NUM_CM-1:0]       cm_en_in,
    input  logic [NUM_CM*RW-1:0]    cm_rd_in,
    input  logic [NUM_CM*ROB_W-1:0] cm_tag_in,
    input  logic [NUM_CM*XLEN-1:0]  cm_val_in,
    input  logic                    rollback_in
`ifdef RRF_COMMIT_CNT_EN
    ,
    output logic [31:0]             cm_cnt_out
`endif
);

    logic [XLEN-1:0]  value_q [NREG];
    logic [XLEN-1:0]  value_d [NREG];
    logic             busy_q  [NREG];
    logic             busy_d  [NREG];
    logic [ROB_W-1:0] tag_q   [NREG];
    logic [ROB_W-1:0] tag_d   [NREG];

    // Next state: commits in port order, then rollback, then rename (rename wins last).
    always_comb begin
        value_d = value_q;
        busy_d  = busy_q;
        tag_d   = tag_q;
        for (int j = 0; j < NUM_CM; j++) begin
            if (cm_en_in[j] && (cm_rd_in[j*RW +: RW] != RW'(REG_ZERO))) begin
                value_d[cm_rd_in[j*RW +: RW]] = cm_val_in[j*XLEN +: XLEN];
                // Compare against pre-edge tag so any port of the cycle can clear.
                if (busy_q[cm_rd_in[j*RW +: RW]] &&
                    (tag_q[cm_rd_in[j*RW +: RW]] == cm_tag_in[j*ROB_W +: ROB_W])) begin
                    busy_d[cm_rd_in[j*RW +: RW]] = 1'b0;
                    tag_d[cm_rd_in[j*RW +: RW]]  = ROB_W'(TAG_NONE);
                end
            end
        end
        if (rollback_in) begin
            for (int r = 0; r < NREG; r++) begin
                busy_d[r] = 1'b0;
                tag_d[r]  = ROB_W'(TAG_NONE);
            end
        end else if (ren_en_in && (ren_rd_in != RW'(REG_ZERO))) begin
            busy_d[ren_rd_in] = 1'b1;
            tag_d[ren_rd_in]  = ren_tag_in;
        end
    end

    // State register; holds everything while rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int r = 0; r < NREG; r++) begin
                value_q[r] <= '0;
                busy_q[r]  <= 1'b0;
                tag_q[r]   <= '0;
            end
        end else if (rdy_in) begin
            value_q <= value_d;
            busy_q  <= busy_d;
            tag_q   <= tag_d;
        end
    end

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            rrf_read_port #(
                .XLEN   (XLEN),
                .RW     (RW),
                .ROB_W  (ROB_W),
                .NUM_CM (NUM_CM)
            ) u_rd (
                .rs_i       (rs_in[k*RW +: RW]),
                .reg_val_i  (value_q[rs_in[k*RW +: RW]]),
                .reg_busy_i (busy_q[rs_in[k*RW +: RW]]),
                .reg_tag_i  (tag_q[rs_in[k*RW +: RW]]),
                .cm_en_i    (cm_en_in),
                .cm_rd_i    (cm_rd_in),
                .cm_tag_i   (cm_tag_in),
                .cm_val_i   (cm_val_in),
                .val_o      (val_out[k*XLEN +: XLEN]),
                .busy_o     (busy_out[k]),
                .tag_o      (tag_out[k*ROB_W +: ROB_W])
            );
        end
    endgenerate

`ifdef RRF_COMMIT_CNT_EN
    logic [31:0] cm_cnt_q;
    logic [31:0] cm_cnt_d;

    // Counter advances by the number of valid commit ports; rollback has no effect.
    always_comb begin
        cm_cnt_d = cm_cnt_q;
        for (int j = 0; j < NUM_CM; j++) begin
            cm_cnt_d = cm_cnt_d + {31'd0, cm_en_in[j]};
        end
    end

    // Commit counter register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cm_cnt_q <= '0;
        end else if (rdy_in) begin
            cm_cnt_q <= cm_cnt_d;
        end
    end

    assign cm_cnt_out = cm_cnt_q;
`endif

endmodule : rename_reg_file

`default_nettype wire

// File: tb/tb_rename_reg_file.sv
// ============================================================================
// Module : tb_rename_reg_file
// Brief  : Self-checking bench for rename_reg_file (default parameters).
//          Build with RRF_COMMIT_CNT_EN to also cover the commit counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rename_reg_file;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int ROB_W  = 4;
    localparam int NUM_RD = 2;
    localparam int NUM_CM = 2;
    localparam int RW     = 5;

    logic                    clk_in = 1'b0;
    logic                    rst_n_in;
    logic                    rdy_in;
    logic [NUM_RD*RW-1:0]    rs_in;
    logic [NUM_RD*XLEN-1:0]  val_out;
    logic [NUM_RD-1:0]       busy_out;
    logic [NUM_RD*ROB_W-1:0] tag_out;
    logic                    ren_en_in;
    logic [RW-1:0]           ren_rd_in;
    logic [ROB_W-1:0]        ren_tag_in;
    logic [NUM_CM-1:0]       cm_en_in;
    logic [NUM_CM*RW-1:0]    cm_rd_in;
    logic [NUM_CM*ROB_W-1:0] cm_tag_in;
    logic [NUM_CM*XLEN-1:0]  cm_val_in;
    logic                    rollback_in;
`ifdef RRF_COMMIT_CNT_EN
    logic [31:0]             cm_cnt_out;
`endif

    int checks   = 0;
    int failures = 0;

    rename_reg_file #(
        .XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NUM_RD(NUM_RD), .NUM_CM(NUM_CM)
    ) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .rdy_in      (rdy_in),
        .rs_in       (rs_in),
        .val_out     (val_out),
        .busy_out    (busy_out),
        .tag_out     (tag_out),
        .ren_en_in   (ren_en_in),
        .ren_rd_in   (ren_rd_in),
        .ren_tag_in  (ren_tag_in),
        .cm_en_in    (cm_en_in),
        .cm_rd_in    (cm_rd_in),
        .cm_tag_in   (cm_tag_in),
        .cm_val_in   (cm_val_in),
        .rollback_in (rollback_in)
`ifdef RRF_COMMIT_CNT_EN
        ,
        .cm_cnt_out  (cm_cnt_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    // ---------------- behavioural model ----------------
    logic [XLEN-1:0]  m_val  [NREG];
    logic             m_busy [NREG];
    logic [ROB_W-1:0] m_tag  [NREG];
    logic [31:0]      m_cnt;

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int r = 0; r < NREG; r++) begin
                m_val[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
            end
            m_cnt = '0;
        end else if (rdy_in) begin
            logic             clr [NREG];
            logic [ROB_W-1:0] old_tag [NREG];
            for (int r = 0; r < NREG; r++) begin
                clr[r] = 1'b0; old_tag[r] = m_tag[r];
            end
            for (int j = 0; j < NUM_CM; j++) begin
                int rd;
                rd = int'(cm_rd_in[j*RW +: RW]);
                if (cm_en_in[j]) begin
                    m_cnt = m_cnt + 1;
                    if (rd != 0) begin
                        m_val[rd] = cm_val_in[j*XLEN +: XLEN];
                        if (m_busy[rd] && old_tag[rd] == cm_tag_in[j*ROB_W +: ROB_W])
                            clr[rd] = 1'b1;
                    end
                end
            end
            for (int r = 0; r < NREG; r++) begin
                if (clr[r] || rollback_in) begin
                    m_busy[r] = 1'b0; m_tag[r] = '0;
                end
            end
            if (!rollback_in && ren_en_in && ren_rd_in != 0) begin
                m_busy[ren_rd_in] = 1'b1;
                m_tag[ren_rd_in]  = ren_tag_in;
            end
        end
    end

    task automatic model_read(input int rs, output logic [XLEN-1:0] v,
                              output logic b, output logic [ROB_W-1:0] t);
        logic hit_clr;
        hit_clr = 1'b0;
        if (rs == 0) begin
            v = '0; b = 1'b0; t = '0;
        end else begin
            v = m_val[rs]; b = m_busy[rs]; t = m_tag[rs];
            for (int j = 0; j < NUM_CM; j++) begin
                if (cm_en_in[j] && int'(cm_rd_in[j*RW +: RW]) == rs) begin
                    v = cm_val_in[j*XLEN +: XLEN];
                    if (m_busy[rs] && cm_tag_in[j*ROB_W +: ROB_W] == m_tag[rs])
                        hit_clr = 1'b1;
                end
            end
            if (hit_clr) begin
                b = 1'b0; t = '0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every read port against the model, mid-cycle.
    bit run_cmp = 1'b0;
    always @(negedge clk_in) begin
        if (run_cmp) begin
            for (int k = 0; k < NUM_RD; k++) begin
                logic [XLEN-1:0]  ev;
                logic             eb;
                logic [ROB_W-1:0] et;
                model_read(int'(rs_in[k*RW +: RW]), ev, eb, et);
                check($sformatf("cmp_val%0d", k),  val_out[k*XLEN +: XLEN], ev);
                check($sformatf("cmp_busy%0d", k), {31'd0, busy_out[k]}, {31'd0, eb});
                check($sformatf("cmp_tag%0d", k),  {28'd0, tag_out[k*ROB_W +: ROB_W]}, {28'd0, et});
            end
`ifdef RRF_COMMIT_CNT_EN
            check("cmp_cnt", cm_cnt_out, m_cnt);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk_in); #1;
    endtask

    task automatic idle();
        ren_en_in = 0; ren_rd_in = 0; ren_tag_in = 0;
        cm_en_in = 0; cm_rd_in = 0; cm_tag_in = 0; cm_val_in = 0;
        rollback_in = 0;
    endtask

    task automatic cm(input int j, input int rd, input int tag, input logic [31:0] v);
        cm_en_in[j] = 1'b1;
        cm_rd_in[j*RW +: RW] = RW'(rd);
        cm_tag_in[j*ROB_W +: ROB_W] = ROB_W'(tag);
        cm_val_in[j*XLEN +: XLEN] = v;
    endtask

    task automatic ren(input int rd, input int tag);
        ren_en_in = 1'b1; ren_rd_in = RW'(rd); ren_tag_in = ROB_W'(tag);
    endtask

    task automatic rd0(input string nm, input int rs,
                       input logic [31:0] ev, input logic eb, input int et);
        rs_in[RW-1:0] = RW'(rs);
        #1;
        check({nm, "_val"},  val_out[XLEN-1:0], ev);
        check({nm, "_busy"}, {31'd0, busy_out[0]}, {31'd0, eb});
        check({nm, "_tag"},  {28'd0, tag_out[ROB_W-1:0]}, 32'(et));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n_in = 1'b0; rdy_in = 1'b1; idle();
        rs_in = {RW'(5), RW'(5)};
        #3;
        check("rst_val1", val_out[XLEN +: XLEN], 32'h0);
        check("rst_busy1", {31'd0, busy_out[1]}, 32'h0);
        rd0("rst", 5, 32'h0, 1'b0, 0);
        step(); step();
        rst_n_in = 1'b1;
        run_cmp = 1'b1;
        step();
        rd0("post_rst", 5, 32'h0, 1'b0, 0);

        // Rename then matching commit with same-cycle forwarding.
        ren(5, 3); step(); idle();
        rd0("ren5", 5, 32'h0, 1'b1, 3);
        cm(0, 5, 3, 32'hDEAD);
        rd0("fwd5", 5, 32'hDEAD, 1'b0, 0);
        step(); idle();
        rd0("cm5", 5, 32'hDEAD, 1'b0, 0);

        // Stale-tag commit updates value only.
        ren(7, 2); step(); ren(7, 6); step(); idle();
        cm(0, 7, 2, 32'h11);
        rd0("stale_fwd7", 7, 32'h11, 1'b1, 6);
        step(); idle();
        rd0("stale7", 7, 32'h11, 1'b1, 6);

        // Two commits to one register: youngest value wins, tag 4 clears.
        ren(9, 4); step(); idle();
        cm(0, 9, 1, 32'hA); cm(1, 9, 4, 32'hB);
        rd0("dual_fwd9", 9, 32'hB, 1'b0, 0);
        step(); idle();
        rd0("dual9", 9, 32'hB, 1'b0, 0);

        // Rollback drops rename, clears all busy, commit still writes.
        ren(10, 7); step(); idle();
        ren(3, 5); rollback_in = 1'b1; cm(0, 8, 0, 32'h77);
        step(); idle();
        rd0("rb3", 3, 32'h0, 1'b0, 0);
        rd0("rb10", 10, 32'h0, 1'b0, 0);
        rd0("rb7", 7, 32'h11, 1'b0, 0);
        rd0("rb8", 8, 32'h77, 1'b0, 0);

        // Rename overrides a same-cycle clear on the same register.
        ren(6, 1); step(); idle();
        ren(6, 2); cm(0, 6, 1, 32'h66); step(); idle();
        rd0("ovr6", 6, 32'h66, 1'b1, 2);

        // Register 0 ignores rename and commit.
        ren(0, 1); cm(0, 0, 0, 32'h55);
        rd0("x0_fwd", 0, 32'h0, 1'b0, 0);
        step(); idle();
        rd0("x0", 0, 32'h0, 1'b0, 0);

        // rdy low holds state.
        rdy_in = 1'b0; ren(4, 2); cm(0, 5, 0, 32'h1234); step(); idle();
        rdy_in = 1'b1;
        rd0("hold4", 4, 32'h0, 1'b0, 0);
        rd0("hold5", 5, 32'hDEAD, 1'b0, 0);

        // Three cycles of two commits each.
        for (int c = 0; c < 3; c++) begin
            cm(0, 11, 0, 32'(c)); cm(1, 12, 0, 32'(c + 100)); step();
        end
        idle();
        rd0("x12", 12, 32'd102, 1'b0, 0);
        rs_in[RW +: RW] = RW'(11); #1;
        check("x11_p1", val_out[XLEN +: XLEN], 32'd2);
`ifdef RRF_COMMIT_CNT_EN
        // 1+1+2+1+1+1 commits earlier (rdy-low cycle excluded), plus 6.
        check("cnt", cm_cnt_out, 32'd13);
`endif

        // Asynchronous reset mid-cycle.
        rs_in[RW-1:0] = RW'(5);
        #1 rst_n_in = 1'b0;
        #1;
        rd0("async_rst", 5, 32'h0, 1'b0, 0);
        rst_n_in = 1'b1;
        step(); step();
        run_cmp = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule : tb_rename_reg_file

`default_nettype wire
